ram_1r1w_be: RTL and testbench

//  Parametrised 1-read/1-write synchronous block RAM for the RV32I core, used for IF instruction

---
 rtl/ram_1r1w_be_pkg.sv | 26 ++
 rtl/ram_1r1w_be_if.sv | 37 +++
 rtl/ram_1r1w_be_core.sv | 38 +++
 rtl/ram_1r1w_be.sv | 166 ++++++++++++++++
 tb/tb_ram_1r1w_be.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ram_1r1w_be_pkg.sv
// ram_1r1w_be_pkg
//   Shared definitions for the byte-enable 1R1W RAM.
//   - state_e:   clear sequencer states
//   - dwidth_ok: data width must be a non-zero multiple of 8
//   - rd_lat_ok: read latency may only be 1 or 2
//   - nb_of:     number of byte lanes for a data width
package ram_1r1w_be_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic bit dwidth_ok(input int dw);
    return (dw > 0) && ((dw % 8) == 0);
  endfunction

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int nb_of(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ram_1r1w_be_if.sv
// ram_1r1w_be_if
//   Bus between a requester (IF/MA stage or loader) and the RAM.
//   ram_radr/ram_ren            read address / request
//   ram_rdata/ram_rvalid        read data / one-cycle completion strobe
//   ram_wadr/ram_wdata/ram_wbe  write address / data / byte enables
//   ram_wen                     write request
//   init_busy                   clear sequence running, requests ignored
//   Modports: master (requester), slave (RAM).
interface ram_1r1w_be_if
  import ram_1r1w_be_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  localparam int NB = nb_of(DWIDTH);

  logic [AWIDTH-1:0] ram_radr;
  logic              ram_ren;
  logic [DWIDTH-1:0] ram_rdata;
  logic              ram_rvalid;
  logic [AWIDTH-1:0] ram_wadr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [NB-1:0]     ram_wbe;
  logic              ram_wen;
  logic              init_busy;

  modport master (
    output ram_radr, ram_ren, ram_wadr, ram_wdata, ram_wbe, ram_wen,
    input  ram_rdata, ram_rvalid, init_busy
  );

  modport slave (
    input  ram_radr, ram_ren, ram_wadr, ram_wdata, ram_wbe, ram_wen,
    output ram_rdata, ram_rvalid, init_busy
  );

endinterface

// File: rtl/ram_1r1w_be_core.sv
// ram_1r1w_be_core
//   Plain storage array: per-byte write port and a registered, read-first
//   read port. No reset and no control logic so it maps onto block RAM.
//   clk    clock
//   re     read enable; rdata holds while low
//   raddr  read word address
//   rdata  registered read data (contents before a same-edge write)
//   we     per-byte write enables
//   waddr  write word address
//   wdata  write data
module ram_1r1w_be_core #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int NB     = 4
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata,
  input  logic [NB-1:0]     we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata
);

  (* ram_style = "block" *)
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_1r1w_be.sv
// ram_1r1w_be
//   1R1W synchronous RAM with byte-enable writes, 1- or 2-cycle read latency,
//   read-valid strobe, optional write-first bypass on address collision and
//   a zeroing sequencer that runs after reset.
//   clk  system clock
//   rst  synchronous reset, active high
//   bus  slave side of ram_1r1w_be_if
//
//   state    | meaning
//   ST_CLEAR | zeroing ram[cnt] each cycle, requests ignored, init_busy=1
//   ST_IDLE  | normal read/write operation
module ram_1r1w_be
  import ram_1r1w_be_pkg::*;
#(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 32,
  parameter int RD_LAT     = 1,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1
) (
  input logic          clk,
  input logic          rst,
  ram_1r1w_be_if.slave bus
);

  localparam int NB = nb_of(DWIDTH);

  if (!dwidth_ok(DWIDTH)) begin : g_bad_dwidth
    $error("ram_1r1w_be: DWIDTH must be a multiple of 8");
  end
  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_1r1w_be: RD_LAT must be 1 or 2");
  end

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              clearing, rd_acc, wr_acc;

  assign clearing = (state_q == ST_CLEAR);
  assign rd_acc   = bus.ram_ren & ~clearing;
  assign wr_acc   = bus.ram_wen & ~clearing;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write port: the sequencer owns it while clearing.
  logic [NB-1:0]     core_we;
  logic [AWIDTH-1:0] core_waddr;
  logic [DWIDTH-1:0] core_wdata, core_rdata;

  always_comb begin
    core_we    = '0;
    core_waddr = bus.ram_wadr;
    core_wdata = bus.ram_wdata;
    if (clearing) begin
      core_we    = '1;
      core_waddr = cnt_q;
      core_wdata = '0;
    end else if (wr_acc) begin
      core_we    = bus.ram_wbe;
    end
    if (rst) core_we = '0;
  end

  ram_1r1w_be_core #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH),
    .NB    (NB)
  ) u_core (
    .clk  (clk),
    .re   (rd_acc),
    .raddr(bus.ram_radr),
    .rdata(core_rdata),
    .we   (core_we),
    .waddr(core_waddr),
    .wdata(core_wdata)
  );

  // First read stage. The core returns pre-write data; on a same-address
  // collision with BYPASS the written bytes are overlaid from mask/bdata.
  // zero_q forces a zero result until the first read after reset, since the
  // core's read register has no reset.
  logic              v1_q, v1_d, zero_q, zero_d;
  logic [NB-1:0]     mask_q, mask_d;
  logic [DWIDTH-1:0] bdata_q, bdata_d, word1;

  always_comb begin
    v1_d    = rd_acc;
    zero_d  = zero_q;
    mask_d  = mask_q;
    bdata_d = bdata_q;
    if (rd_acc) begin
      zero_d  = 1'b0;
      bdata_d = bus.ram_wdata;
      mask_d  = '0;
      if ((BYPASS != 0) && wr_acc && (bus.ram_radr == bus.ram_wadr)) mask_d = bus.ram_wbe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      zero_q  <= 1'b1;
      mask_q  <= '0;
      bdata_q <= '0;
    end else begin
      v1_q    <= v1_d;
      zero_q  <= zero_d;
      mask_q  <= mask_d;
      bdata_q <= bdata_d;
    end
  end

  always_comb begin
    word1 = core_rdata;
    for (int b = 0; b < NB; b++) begin
      if (mask_q[b]) word1[8*b +: 8] = bdata_q[8*b +: 8];
    end
    if (zero_q) word1 = '0;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DWIDTH-1:0] rdata2_q, rdata2_d;
    logic              v2_q, v2_d;

    always_comb begin
      rdata2_d = v1_q ? word1 : rdata2_q;
      v2_d     = v1_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata2_q <= '0;
        v2_q     <= 1'b0;
      end else begin
        rdata2_q <= rdata2_d;
        v2_q     <= v2_d;
      end
    end

    assign bus.ram_rdata  = rdata2_q;
    assign bus.ram_rvalid = v2_q;
  end else begin : g_lat1
    assign bus.ram_rdata  = word1;
    assign bus.ram_rvalid = v1_q;
  end

  assign bus.init_busy = clearing;

endmodule

// File: tb/tb_ram_1r1w_be.sv
// tb_ram_1r1w_be
//   Directed bench driving three RAM instances with identical stimulus:
//   a: RD_LAT=1 BYPASS=1 CLR_ON_RST=1
//   b: RD_LAT=2 BYPASS=0 CLR_ON_RST=1
//   c: RD_LAT=1 BYPASS=0 CLR_ON_RST=0
module tb_ram_1r1w_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  radr, wadr;
  logic        ren, wen;
  logic [31:0] wdata;
  logic [3:0]  wbe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_1r1w_be_if #(.AWIDTH(4), .DWIDTH(32)) bus_a ();
  ram_1r1w_be_if #(.AWIDTH(4), .DWIDTH(32)) bus_b ();
  ram_1r1w_be_if #(.AWIDTH(4), .DWIDTH(32)) bus_c ();

  assign bus_a.ram_radr = radr;  assign bus_b.ram_radr = radr;  assign bus_c.ram_radr = radr;
  assign bus_a.ram_ren  = ren;   assign bus_b.ram_ren  = ren;   assign bus_c.ram_ren  = ren;
  assign bus_a.ram_wadr = wadr;  assign bus_b.ram_wadr = wadr;  assign bus_c.ram_wadr = wadr;
  assign bus_a.ram_wdata = wdata; assign bus_b.ram_wdata = wdata; assign bus_c.ram_wdata = wdata;
  assign bus_a.ram_wbe  = wbe;   assign bus_b.ram_wbe  = wbe;   assign bus_c.ram_wbe  = wbe;
  assign bus_a.ram_wen  = wen;   assign bus_b.ram_wen  = wen;   assign bus_c.ram_wen  = wen;

  ram_1r1w_be #(.AWIDTH(4), .DWIDTH(32), .RD_LAT(1), .BYPASS(1), .CLR_ON_RST(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ram_1r1w_be #(.AWIDTH(4), .DWIDTH(32), .RD_LAT(2), .BYPASS(0), .CLR_ON_RST(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  ram_1r1w_be #(.AWIDTH(4), .DWIDTH(32), .RD_LAT(1), .BYPASS(0), .CLR_ON_RST(0))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ticks until dut_a leaves the clear state; returns the number of edges.
  task automatic count_busy(output int n, output int rv_seen);
    n = 0;
    rv_seen = 0;
    while (bus_a.init_busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus_a.ram_rvalid !== 1'b0 || bus_b.ram_rvalid !== 1'b0) rv_seen++;
    end
  endtask

  int n, rv;

  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0; radr = '0; wadr = '0; wdata = '0; wbe = '0;
    tick();
    tick();
    chk("rst_rdata_a", bus_a.ram_rdata, 32'h0);
    chk("rst_rvalid_a", {31'b0, bus_a.ram_rvalid}, 32'h0);
    chk("rst_rdata_b", bus_b.ram_rdata, 32'h0);
    chk("rst_busy_a", {31'b0, bus_a.init_busy}, 32'h1);
    chk("rst_busy_c", {31'b0, bus_c.init_busy}, 32'h0);
    rst = 1'b0;
    count_busy(n, rv);
    chk("clear_len_first", n, 16);
    chk("busy_b_after_clear", {31'b0, bus_b.init_busy}, 32'h0);

    // Fill with junk.
    wen = 1'b1; wbe = 4'hF;
    for (int i = 0; i < 16; i++) begin
      wadr = 4'(i); wdata = 32'h5A5A0000 | i;
      tick();
    end
    wen = 1'b0;

    // Re-clear with requests active, restart mid-way at cnt=9.
    rst = 1'b1; tick(); rst = 1'b0;
    ren = 1'b1; wen = 1'b1; radr = 4'd3; wadr = 4'd3; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    rv = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus_a.ram_rvalid !== 1'b0 || bus_b.ram_rvalid !== 1'b0) rv++;
    end
    chk("busy_mid_clear", {31'b0, bus_a.init_busy}, 32'h1);
    chk("rvalid_during_clear1", rv, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy(n, rv);
    ren = 1'b0; wen = 1'b0;
    chk("clear_len_restart", n, 16);
    chk("rvalid_during_clear2", rv, 0);

    // All words read back zero; a at +1, b at +2.
    for (int i = 0; i <= 16; i++) begin
      ren = (i < 16); radr = 4'(i);
      tick();
      if (i < 16) begin
        chk("zero_rvalid_a", {31'b0, bus_a.ram_rvalid}, 32'h1);
        chk("zero_rdata_a", bus_a.ram_rdata, 32'h0);
      end
      if (i > 0) begin
        chk("zero_rvalid_b", {31'b0, bus_b.ram_rvalid}, 32'h1);
        chk("zero_rdata_b", bus_b.ram_rdata, 32'h0);
      end
    end
    ren = 1'b0;
    tick();
    chk("idle_rvalid_b", {31'b0, bus_b.ram_rvalid}, 32'h0);

    // Byte-enable write merge.
    wen = 1'b1; wadr = 4'd5; wdata = 32'hDEADBEEF; wbe = 4'hF; tick();
    wdata = 32'h000000AA; wbe = 4'h1; tick();
    wen = 1'b0; ren = 1'b1; radr = 4'd5; tick();
    ren = 1'b0;
    chk("be_rdata_a", bus_a.ram_rdata, 32'hDEADBEAA);
    chk("be_rvalid_b_early", {31'b0, bus_b.ram_rvalid}, 32'h0);
    chk("be_rdata_c", bus_c.ram_rdata, 32'hDEADBEAA);
    tick();
    chk("be_rdata_b", bus_b.ram_rdata, 32'hDEADBEAA);
    chk("be_rvalid_b", {31'b0, bus_b.ram_rvalid}, 32'h1);
    chk("be_rvalid_a_once", {31'b0, bus_a.ram_rvalid}, 32'h0);
    chk("be_hold_a", bus_a.ram_rdata, 32'hDEADBEAA);

    // Back-to-back reads of 1..4.
    wen = 1'b1; wbe = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      wadr = 4'(i); wdata = 32'hC0DE0000 | i; tick();
    end
    wen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      ren = (j < 4); radr = 4'(j + 1);
      tick();
      chk("b2b_rvalid_a", {31'b0, bus_a.ram_rvalid}, (j < 4) ? 32'h1 : 32'h0);
      chk("b2b_rdata_a", bus_a.ram_rdata, (j < 4) ? (32'hC0DE0000 | (j + 1)) : 32'hC0DE0004);
      chk("b2b_rvalid_b", {31'b0, bus_b.ram_rvalid}, (j >= 1 && j <= 4) ? 32'h1 : 32'h0);
      if (j >= 1 && j <= 4) chk("b2b_rdata_b", bus_b.ram_rdata, 32'hC0DE0000 | j);
    end
    ren = 1'b0;

    // Same-address collision.
    wen = 1'b1; wadr = 4'd7; wdata = 32'h11223344; wbe = 4'hF; tick();
    ren = 1'b1; radr = 4'd7; wdata = 32'hAABBCCDD; wbe = 4'h3; tick();
    ren = 1'b0; wen = 1'b0;
    chk("col_bypass_a", bus_a.ram_rdata, 32'h1122CCDD);
    chk("col_old_c", bus_c.ram_rdata, 32'h11223344);
    tick();
    chk("col_old_b", bus_b.ram_rdata, 32'h11223344);
    // wbe=0 write must leave the word alone.
    wen = 1'b1; wdata = 32'hFFFFFFFF; wbe = 4'h0; tick();
    wen = 1'b0; ren = 1'b1; tick();
    ren = 1'b0;
    chk("col_after_a", bus_a.ram_rdata, 32'h1122CCDD);
    chk("col_after_c", bus_c.ram_rdata, 32'h1122CCDD);
    tick();
    chk("col_after_b", bus_b.ram_rdata, 32'h1122CCDD);

    // Reset with reads in flight.
    ren = 1'b1; radr = 4'd5; tick();
    rst = 1'b1; radr = 4'd7; tick();
    chk("inflight_rdata_a", bus_a.ram_rdata, 32'h0);
    chk("inflight_rdata_b", bus_b.ram_rdata, 32'h0);
    chk("inflight_rvalid_a", {31'b0, bus_a.ram_rvalid}, 32'h0);
    chk("inflight_rvalid_b", {31'b0, bus_b.ram_rvalid}, 32'h0);
    rst = 1'b0; ren = 1'b0;
    count_busy(n, rv);
    chk("inflight_no_rvalid", rv, 0);
    chk("inflight_clear_len", n, 16);
    chk("inflight_rdata_b_hold", bus_b.ram_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
